// File: rtl/flush_stall_ctrl.sv
// Pipeline hazard controller: detects EX-resolved redirects and ID/EX load-use
// hazards, drives flush/stall windows and keeps saturating event counters.
module flush_stall_ctrl #(
  parameter int XLEN              = 32,
  parameter int INSN_BYTES        = 4,
  parameter int FLUSH_CYCLES      = 2,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_npc,
  input  logic             ex_is_load,
  input  logic             ex_we,
  input  logic [4:0]       ex_rd,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  output logic             is_branch,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MAXC = (FLUSH_CYCLES > LOAD_STALL_CYCLES) ? FLUSH_CYCLES : LOAD_STALL_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] FL_LOAD = CW'(FLUSH_CYCLES - 1);
  localparam logic [CW-1:0] ST_LOAD = CW'(LOAD_STALL_CYCLES - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [1:0] {IDLE, FLUSH, STALL} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [XLEN-1:0]  seq_pc;
  logic             br_raw, lu_raw, load_hazard, flush_w, stall_w;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign seq_pc = ex_pc + XLEN'(INSN_BYTES);
  assign br_raw = ex_valid & (ex_npc != seq_pc);
  assign lu_raw = ex_valid & ex_is_load & ex_we & (ex_rd != 5'd0) & id_valid &
                  ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));

  assign is_branch   = br_raw & (state_q != FLUSH) & ~cpu_rst;
  assign load_hazard = lu_raw & ~is_branch & (state_q == IDLE) & ~cpu_rst;

  // cnt holds the window cycles still owed after the current one.
  assign flush_w = is_branch | ((state_q == FLUSH) & ~cpu_rst);
  assign stall_w = (load_hazard | ((state_q == STALL) & ~cpu_rst)) & ~flush_w;

  assign redirect_valid = is_branch;
  assign redirect_pc    = cpu_rst ? '0 : ex_npc;
  assign flush_if_id    = flush_w;
  assign flush_id_ex    = flush_w | stall_w;
  assign stall_pc       = stall_w;
  assign stall_if_id    = stall_w;
  assign branch_cnt     = cpu_rst ? '0 : branch_cnt_q;
  assign stall_cnt      = cpu_rst ? '0 : stall_cnt_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    branch_cnt_d = is_branch ? sat_inc(branch_cnt_q) : branch_cnt_q;
    stall_cnt_d  = stall_w ? sat_inc(stall_cnt_q) : stall_cnt_q;
    case (state_q)
      IDLE, STALL: begin
        if (is_branch) begin
          state_d = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
          cnt_d   = FL_LOAD;
        end else if (load_hazard) begin
          state_d = (LOAD_STALL_CYCLES > 1) ? STALL : IDLE;
          cnt_d   = ST_LOAD;
        end else if (state_q == STALL) begin
          state_d = (cnt_q <= ONE) ? IDLE : STALL;
          cnt_d   = cnt_q - ONE;
        end
      end
      FLUSH: begin
        state_d = (cnt_q <= ONE) ? IDLE : FLUSH;
        cnt_d   = cnt_q - ONE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      branch_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      branch_cnt_q <= branch_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_flush_stall_ctrl.sv
// Bench for flush_stall_ctrl: directed vector table, saturation sequence and
// randomized traffic against a remaining-cycles behavioural model.
module tb_flush_stall_ctrl;

  localparam int FC   = 2;
  localparam int LSC  = 3;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, ex_valid, ex_is_load, ex_we, id_valid, u1, u2;
  logic [31:0]   ex_pc, ex_npc;
  logic [4:0]    ex_rd, rs1, rs2;
  logic          is_branch, redirect_valid, flush_if_id, flush_id_ex, stall_pc, stall_if_id;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] branch_cnt, stall_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  flush_stall_ctrl #(.XLEN(32), .INSN_BYTES(4), .FLUSH_CYCLES(FC),
                     .LOAD_STALL_CYCLES(LSC), .CNT_W(CW)) dut (
    .cpu_clk(clk), .cpu_rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_npc(ex_npc),
    .ex_is_load(ex_is_load), .ex_we(ex_we), .ex_rd(ex_rd), .id_valid(id_valid),
    .id_rs1(rs1), .id_rs2(rs2), .id_rs1_used(u1), .id_rs2_used(u2),
    .is_branch(is_branch), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .stall_pc(stall_pc),
    .stall_if_id(stall_if_id), .branch_cnt(branch_cnt), .stall_cnt(stall_cnt));

  typedef struct {
    logic        rst, v;
    logic [31:0] pc, npc;
    logic        ld, we;
    logic [4:0]  rd;
    logic        idv;
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic        e_br, e_fl, e_fie, e_st;
    int          e_bc, e_sc;
  } vec_t;

  vec_t tbl[$];

  // Model: windows tracked as cycles still owed after the current one.
  int   m_fl, m_st, m_bc, m_sc;
  logic m_br, m_haz, m_flo, m_sto, m_fie;

  function automatic vec_t mk(input logic r, v, input logic [31:0] pc, npc,
                              input logic ld, we, input logic [4:0] rd, input logic idv,
                              input logic [4:0] a, b, input logic ua, ub,
                              input logic br, fl, fie, st, input int bc, sc);
    vec_t t;
    t.rst = r; t.v = v; t.pc = pc; t.npc = npc; t.ld = ld; t.we = we; t.rd = rd;
    t.idv = idv; t.rs1 = a; t.rs2 = b; t.u1 = ua; t.u2 = ub;
    t.e_br = br; t.e_fl = fl; t.e_fie = fie; t.e_st = st; t.e_bc = bc; t.e_sc = sc;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t t);
    rst = t.rst; ex_valid = t.v; ex_pc = t.pc; ex_npc = t.npc; ex_is_load = t.ld;
    ex_we = t.we; ex_rd = t.rd; id_valid = t.idv; rs1 = t.rs1; rs2 = t.rs2;
    u1 = t.u1; u2 = t.u2;
  endtask

  task automatic model_eval();
    logic in_flush, lu;
    in_flush = (m_fl > 0);
    m_br  = !rst && !in_flush && ex_valid && (ex_npc != 32'(ex_pc + 32'd4));
    lu    = ex_valid && ex_is_load && ex_we && (ex_rd != 0) && id_valid &&
            ((u1 && rs1 == ex_rd) || (u2 && rs2 == ex_rd));
    m_haz = !rst && lu && !m_br && !in_flush && (m_st == 0);
    m_flo = !rst && (m_br || in_flush);
    m_sto = !rst && (m_haz || m_st > 0) && !m_flo;
    m_fie = m_flo || m_sto;
  endtask

  task automatic model_commit();
    if (rst) begin
      m_fl = 0; m_st = 0; m_bc = 0; m_sc = 0;
    end else begin
      if (m_br) begin m_fl = FC - 1; m_st = 0; end
      else if (m_fl > 0) m_fl--;
      else if (m_haz) m_st = LSC - 1;
      else if (m_st > 0) m_st--;
      if (m_br && m_bc < CMAX) m_bc++;
      if (m_sto && m_sc < CMAX) m_sc++;
    end
  endtask

  // One clock: compare at negedge (against table or model), then advance.
  task automatic cycle(input bit use_model, input vec_t t, input string tag);
    @(negedge clk);
    model_eval();
    if (use_model) begin
      chk({tag, "_br"},  {is_branch, redirect_valid}, {m_br, m_br});
      chk({tag, "_fl"},  {flush_if_id, flush_id_ex}, {m_flo, m_fie});
      chk({tag, "_st"},  {stall_pc, stall_if_id}, {m_sto, m_sto});
      chk({tag, "_cnt"}, {branch_cnt, stall_cnt},
          {(rst ? 3'd0 : 3'(m_bc)), (rst ? 3'd0 : 3'(m_sc))});
      if (m_br) chk({tag, "_rpc"}, redirect_pc, ex_npc);
    end else begin
      chk({tag, "_br"},  {is_branch, redirect_valid}, {t.e_br, t.e_br});
      chk({tag, "_fl"},  {flush_if_id, flush_id_ex}, {t.e_fl, t.e_fie});
      chk({tag, "_st"},  {stall_pc, stall_if_id}, {t.e_st, t.e_st});
      chk({tag, "_cnt"}, {branch_cnt, stall_cnt}, {3'(t.e_bc), 3'(t.e_sc)});
      if (t.e_br) chk({tag, "_rpc"}, redirect_pc, t.npc);
    end
    @(posedge clk);
    model_commit();
    #1;
  endtask

  vec_t idle, bv;

  initial begin
    m_fl = 0; m_st = 0; m_bc = 0; m_sc = 0;
    idle = mk(0,0,32'h0,32'h0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0);
    //          rst v  pc          npc         ld we rd idv rs1 rs2 u1 u2  br fl fie st bc sc
    tbl.push_back(mk(1,1,32'h100,     32'h200,     0,0,0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0,1,32'h100,     32'h104,     0,0,0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0,1,32'h100,     32'h200,     0,0,0, 0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0,1,32'h200,     32'h300,     0,0,0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0,0,32'h0,       32'h0,       0,0,0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0,1,32'h300,     32'h304,     1,1,5, 1, 1, 5, 0, 1,  0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0,0,32'h0,       32'h0,       0,0,0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 1, 1));
    tbl.push_back(mk(0,0,32'h0,       32'h0,       0,0,0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 1, 2));
    tbl.push_back(mk(0,0,32'h0,       32'h0,       0,0,0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 3));
    tbl.push_back(mk(0,1,32'h300,     32'h304,     1,1,0, 1, 0, 0, 1, 1,  0, 0, 0, 0, 1, 3));
    tbl.push_back(mk(0,1,32'h300,     32'h304,     1,1,5, 1, 1, 5, 0, 0,  0, 0, 0, 0, 1, 3));
    tbl.push_back(mk(0,1,32'h300,     32'h304,     1,1,7, 1, 7, 2, 1, 0,  0, 0, 1, 1, 1, 3));
    tbl.push_back(mk(0,1,32'h40,      32'h80,      0,0,0, 0, 0, 0, 0, 0,  1, 1, 1, 0, 1, 4));
    tbl.push_back(mk(0,0,32'h0,       32'h0,       0,0,0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 2, 4));
    tbl.push_back(mk(0,0,32'h0,       32'h0,       0,0,0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 4));
    tbl.push_back(mk(0,1,32'hFFFFFFFC,32'h0,       0,0,0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 4));
    tbl.push_back(mk(0,1,32'h100,     32'h200,     1,1,5, 1, 5, 0, 1, 0,  1, 1, 1, 0, 2, 4));
    tbl.push_back(mk(0,1,32'h200,     32'h204,     1,1,5, 1, 5, 0, 1, 0,  0, 1, 1, 0, 3, 4));
    tbl.push_back(mk(0,1,32'h0,       32'h8,       0,0,0, 0, 0, 0, 0, 0,  1, 1, 1, 0, 3, 4));
    tbl.push_back(mk(1,1,32'h0,       32'h10,      1,1,5, 1, 5, 5, 1, 1,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0,0,32'h0,       32'h0,       0,0,0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0,1,32'h10,      32'h20,      0,0,0, 0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0));

    drive(idle);
    rst = 1'b1;
    @(posedge clk); #1;
    model_commit();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      cycle(0, tbl[i], $sformatf("vec%0d", i));
    end

    // Saturation: a mismatch held for 20 cycles is accepted every FC cycles.
    bv = idle; bv.rst = 1'b1;
    drive(bv);
    cycle(1, bv, "satrst");
    bv = mk(0,1,32'h0,32'h100,0,0,0,0,0,0,0,0, 0,0,0,0,0,0);
    drive(bv);
    for (int i = 0; i < 20; i++) cycle(1, bv, "sat");
    drive(idle);
    @(negedge clk);
    chk("sat_branch_cnt", branch_cnt, 3'd7);
    @(posedge clk); model_commit(); #1;

    for (int i = 0; i < 3000; i++) begin
      vec_t r;
      r = idle;
      r.rst = ($urandom_range(0, 63) == 0);
      r.v   = ($urandom_range(0, 3) != 0);
      r.pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : ($urandom() & 32'hFFFFFFFC);
      r.npc = ($urandom_range(0, 2) != 0) ? 32'(r.pc + 32'd4) : $urandom();
      r.ld  = $urandom_range(0, 1);
      r.we  = ($urandom_range(0, 3) != 0);
      r.rd  = 5'($urandom_range(0, 3));
      r.idv = ($urandom_range(0, 3) != 0);
      r.rs1 = 5'($urandom_range(0, 3));
      r.rs2 = 5'($urandom_range(0, 3));
      r.u1  = $urandom_range(0, 1);
      r.u2  = $urandom_range(0, 1);
      drive(r);
      cycle(1, r, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flush_stall_ctrl.md
# flush_stall_ctrl

Parametrised pipeline hazard controller for the 5-stage core, sitting beside the ID/EX/MEM control path. Generalises the combinational branch-detect check into a sequential controller. It detects control-flow changes resolved in EX (actual next PC differs from sequential PC) and load-use data hazards between ID and EX. It drives multi-cycle flush and stall windows and a PC redirect, and keeps saturating event counters for performance debug.

## Interface
- XLEN, 32, address/data width
- INSN_BYTES, 4, sequential PC increment
- FLUSH_CYCLES, 2, cycles flush is held per taken redirect (>=1)
- LOAD_STALL_CYCLES, 1, stall cycles per load-use hazard (>=1)
- CNT_W, 16, event counter width
- cpu_clk  in  1  clock; all state updates on rising edge
- cpu_rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX holds a real instruction
- ex_pc  in  XLEN  PC of EX instruction
- ex_npc  in  XLEN  resolved next PC of EX instruction
- ex_is_load  in  1  EX instruction is a load
- ex_we  in  1  EX instruction writes rd
- ex_rd  in  5  EX destination register
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  5 each  ID source registers
- id_rs1_used, id_rs2_used  in  1 each  source actually read
- is_branch  out  1  redirect detected this cycle
- redirect_valid  out  1  load redirect_pc into PC
- redirect_pc  out  XLEN  target PC (= ex_npc)
- flush_if_id  out  1  clear IF/ID register
- flush_id_ex  out  1  insert bubble into ID/EX
- stall_pc  out  1  hold PC
- stall_if_id  out  1  hold IF/ID register
- branch_cnt  out  CNT_W  accepted redirects
- stall_cnt  out  CNT_W  load-use stall cycles

## Operation
- seq_pc = ex_pc + INSN_BYTES, truncated to XLEN (wraps at 2^XLEN).
- br_raw = ex_valid & (ex_npc != seq_pc); is_branch = br_raw & state!=FLUSH & ~cpu_rst.
- lu_raw = ex_valid & ex_is_load & ex_we & ex_rd!=0 & id_valid & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)); load_hazard = lu_raw & ~is_branch & state==IDLE & ~cpu_rst.
- States: IDLE, FLUSH, STALL; down-counter cnt (width fits max(FLUSH_CYCLES, LOAD_STALL_CYCLES)).
- IDLE: is_branch -> FLUSH with cnt=FLUSH_CYCLES-1 (stay IDLE if 0); else load_hazard -> STALL with cnt=LOAD_STALL_CYCLES-1 (stay IDLE if 0).
- FLUSH: EX contents ignored (br_raw, lu_raw masked); cnt==0 -> IDLE, else cnt--.
- STALL: is_branch (EX valid) wins -> FLUSH, cnt=FLUSH_CYCLES-1; else cnt==0 -> IDLE, else cnt--.
- Outputs: redirect_valid = is_branch; redirect_pc = ex_npc (don't-care when redirect_valid=0); flush_if_id = is_branch | state==FLUSH; flush_id_ex = is_branch | load_hazard | state==FLUSH | state==STALL; stall_pc = stall_if_id = (load_hazard | state==STALL) & ~flush_if_id.
- Priority: branch > load-use. Branch and load-use same cycle -> flush only, no stall, stall_cnt unchanged.
- branch_cnt += 1 per cycle with is_branch; stall_cnt += 1 per cycle with stall_pc; both saturate at 2^CNT_W-1.

## Timing
- is_branch, redirect_*, first flush/stall cycle: combinational, same cycle as triggering inputs (zero latency).
- Flush window: exactly FLUSH_CYCLES consecutive cycles of flush_if_id starting at detection cycle.
- Stall window: exactly LOAD_STALL_CYCLES consecutive cycles of stall_pc unless cut short by a branch.
- Reset (any cycle, incl. mid-window): next edge -> state IDLE, cnt 0, counters 0; while cpu_rst high all outputs 0 regardless of inputs.
- Counters update on the edge ending the event cycle; visible next cycle.
- Back-to-back: new branch in the cycle after FLUSH returns to IDLE is accepted normally.

## Test plan
- Sequential flow: ex_pc=0x100, ex_npc=0x104, ex_valid=1 -> is_branch=0, no flush/stall, counters stay 0.
- Taken branch, FLUSH_CYCLES=2: ex_pc=0x100, ex_npc=0x200 -> redirect_valid=1, redirect_pc=0x200, flush_if_id/flush_id_ex high 2 cycles; branch_cnt=1; new mismatch in 2nd cycle ignored.
- Load-use, LOAD_STALL_CYCLES=1: ex load rd=5, id rs2=5 used -> stall_pc=stall_if_id=flush_id_ex=1 one cycle, stall_cnt=1; rd=0 or rs2_used=0 -> no stall.
- Simultaneous branch and load-use (LOAD_STALL_CYCLES=3, branch in 2nd STALL cycle) -> stall drops, FLUSH window runs, stall_cnt=1, branch_cnt=1.
- Wrap and saturation: ex_pc=0xFFFFFFFC, ex_npc=0x0 -> is_branch=0; CNT_W=2 with 5 branches -> branch_cnt=3.
- Reset mid-FLUSH -> outputs 0 during reset, state IDLE and counters 0 after release.
